// File: rtl/fuzzy_defuzz_wavg.sv
// Weighted-average defuzzifier: u = sum(w*c) / sum(w).
// Serial datapath: one MAC per cycle over the captured rule strengths, then a
// restoring divider producing one quotient bit per cycle. One operation in flight.
//
// Ports:
//   clk, rst            clock and synchronous active-high reset
//   in_valid/in_ready   input handshake; in_ready only while idle and not in reset
//   w_flat              unsigned Q1.15 strengths, rule i at [i*W +: W]
//   c_flat              signed Q1.15 consequents, same packing
//   out_valid/out_ready output handshake; result held stable until accepted
//   u                   signed Q1.15 crisp output
//   zero_w              sum(w)==0 for this result (u forced to 0)
module fuzzy_defuzz_wavg #(
    parameter int unsigned N_RULES = 9,
    parameter int unsigned W       = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [N_RULES*W-1:0] w_flat,
    input  logic [N_RULES*W-1:0] c_flat,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [W-1:0]         u,
    output logic                 zero_w
);

    localparam int unsigned NUM_W = 2*W + $clog2(N_RULES);
    localparam int unsigned DEN_W = W + $clog2(N_RULES);
    localparam int unsigned IDX_W = (N_RULES > 1) ? $clog2(N_RULES) : 1;
    localparam int unsigned CNT_W = $clog2(NUM_W);

    localparam logic [W-1:0]     U_MAX = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0]     U_MIN = {1'b1, {(W-1){1'b0}}};
    localparam logic [NUM_W-1:0] POS_LIM = {{(NUM_W-W){1'b0}}, U_MAX};
    localparam logic [NUM_W-1:0] NEG_LIM = {{(NUM_W-W){1'b0}}, U_MIN};

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ACCUM = 3'd1,
        CHECK = 3'd2,
        DIV   = 3'd3,
        FIN   = 3'd4,
        DONE  = 3'd5
    } state_t;

    state_t state, state_nx;

    logic [W-1:0]              w_q [N_RULES];
    logic [W-1:0]              c_q [N_RULES];
    logic [IDX_W-1:0]          idx_q;
    logic [CNT_W-1:0]          cnt_q;
    logic signed [NUM_W-1:0]   num_q;
    logic [DEN_W-1:0]          den_q;
    logic [DEN_W-1:0]          rem_q;
    logic [NUM_W-1:0]          dq_q;
    logic                      neg_q;

    logic signed [2*W:0]       mac_prod;
    logic [NUM_W-1:0]          num_mag;
    logic [DEN_W:0]            rem_sh;
    logic [DEN_W-1:0]          rem_nx;
    logic                      q_bit;
    logic [W-1:0]              u_nx;
    logic                      idx_last;
    logic                      cnt_last;

    assign idx_last = (idx_q == IDX_W'(N_RULES - 1));
    assign cnt_last = (cnt_q == CNT_W'(NUM_W - 1));

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (in_valid)  state_nx = ACCUM;
            ACCUM:   if (idx_last)  state_nx = CHECK;
            CHECK:   state_nx = (den_q == '0) ? DONE : DIV;
            DIV:     if (cnt_last)  state_nx = FIN;
            FIN:     state_nx = DONE;
            DONE:    if (out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Handshake outputs decoded from the state register
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        if (state == IDLE && !rst) in_ready  = 1'b1;
        if (state == DONE)         out_valid = 1'b1;
    end

    // MAC term: strength is unsigned, so widen with a zero before the signed multiply
    always_comb begin
        mac_prod = $signed({1'b0, w_q[0]}) * $signed(c_q[0]);
    end

    // Magnitude of the numerator; cannot overflow since |num| <= N_RULES*2^30
    always_comb begin
        num_mag = num_q;
        if (num_q[NUM_W-1]) num_mag = NUM_W'(-num_q);
    end

    // One restoring-division step: remainder stays below den, so DEN_W bits suffice
    always_comb begin
        rem_sh = {rem_q, dq_q[NUM_W-1]};
        rem_nx = rem_sh[DEN_W-1:0];
        q_bit  = 1'b0;
        if (rem_sh >= {1'b0, den_q}) begin
            rem_nx = DEN_W'(rem_sh - {1'b0, den_q});
            q_bit  = 1'b1;
        end
    end

    // Apply sign and saturate the quotient magnitude to signed W bits
    always_comb begin
        u_nx = W'(dq_q);
        if (neg_q) begin
            if (dq_q > NEG_LIM) u_nx = U_MIN;
            else                u_nx = W'(~dq_q + NUM_W'(1));
        end else if (dq_q > POS_LIM) begin
            u_nx = U_MAX;
        end
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_RULES; i++) begin
                w_q[i] <= '0;
                c_q[i] <= '0;
            end
            idx_q  <= '0;
            cnt_q  <= '0;
            num_q  <= '0;
            den_q  <= '0;
            rem_q  <= '0;
            dq_q   <= '0;
            neg_q  <= 1'b0;
            u      <= '0;
            zero_w <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        for (int i = 0; i < N_RULES; i++) begin
                            w_q[i] <= w_flat[i*W +: W];
                            c_q[i] <= c_flat[i*W +: W];
                        end
                        idx_q <= '0;
                        num_q <= '0;
                        den_q <= '0;
                    end
                end
                ACCUM: begin
                    // Consume rule 0 and shift the rest down
                    num_q <= num_q + NUM_W'(mac_prod);
                    den_q <= den_q + DEN_W'(w_q[0]);
                    for (int i = 0; i < N_RULES - 1; i++) begin
                        w_q[i] <= w_q[i+1];
                        c_q[i] <= c_q[i+1];
                    end
                    w_q[N_RULES-1] <= '0;
                    c_q[N_RULES-1] <= '0;
                    idx_q <= idx_q + IDX_W'(1);
                end
                CHECK: begin
                    if (den_q == '0) begin
                        u      <= '0;
                        zero_w <= 1'b1;
                    end else begin
                        zero_w <= 1'b0;
                        neg_q  <= num_q[NUM_W-1];
                        dq_q   <= num_mag;
                        rem_q  <= '0;
                        cnt_q  <= '0;
                    end
                end
                DIV: begin
                    // Dividend shifts out the top while quotient bits shift in below
                    rem_q <= rem_nx;
                    dq_q  <= {dq_q[NUM_W-2:0], q_bit};
                    cnt_q <= cnt_q + CNT_W'(1);
                end
                FIN: begin
                    u <= u_nx;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fuzzy_defuzz_wavg.sv
module tb_fuzzy_defuzz_wavg;

    logic         clk;
    logic         rst;

    logic         in_valid9, in_ready9, out_valid9, out_ready9, zero_w9;
    logic [143:0] w_flat9, c_flat9;
    logic [15:0]  u9;

    logic         in_valid4, in_ready4, out_valid4, out_ready4, zero_w4;
    logic [63:0]  w_flat4, c_flat4;
    logic [15:0]  u4;

    logic [15:0]  wv9 [9];
    logic [15:0]  cv9 [9];
    logic [15:0]  wv4 [4];
    logic [15:0]  cv4 [4];

    int total;
    int bad;

    fuzzy_defuzz_wavg #(.N_RULES(9), .W(16)) dut9 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid9), .in_ready(in_ready9),
        .w_flat(w_flat9), .c_flat(c_flat9),
        .out_valid(out_valid9), .out_ready(out_ready9),
        .u(u9), .zero_w(zero_w9)
    );

    fuzzy_defuzz_wavg #(.N_RULES(4), .W(16)) dut4 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid4), .in_ready(in_ready4),
        .w_flat(w_flat4), .c_flat(c_flat4),
        .out_valid(out_valid4), .out_ready(out_ready4),
        .u(u4), .zero_w(zero_w4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clear9();
        for (int i = 0; i < 9; i++) begin
            wv9[i] = 16'h0000;
            cv9[i] = 16'h0000;
        end
    endtask

    task automatic pack9();
        for (int i = 0; i < 9; i++) begin
            w_flat9[i*16 +: 16] = wv9[i];
            c_flat9[i*16 +: 16] = cv9[i];
        end
    endtask

    // Issue one op on the 9-rule instance; lat = edges from accept to out_valid, -1 on timeout
    task automatic do_op9(input bit finish_hs, output int lat, output logic [15:0] uo,
                          output logic zo);
        int n;
        n = 0;
        while (!in_ready9 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        pack9();
        in_valid9 = 1'b1;
        @(posedge clk); #1;
        in_valid9 = 1'b0;
        lat = -1;
        for (int k = 1; k <= 200; k++) begin
            @(posedge clk); #1;
            if (out_valid9) begin
                lat = k;
                break;
            end
        end
        uo = u9;
        zo = zero_w9;
        if (finish_hs) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic do_op4(output int lat, output logic [15:0] uo, output logic zo);
        int n;
        n = 0;
        while (!in_ready4 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        for (int i = 0; i < 4; i++) begin
            w_flat4[i*16 +: 16] = wv4[i];
            c_flat4[i*16 +: 16] = cv4[i];
        end
        in_valid4 = 1'b1;
        @(posedge clk); #1;
        in_valid4 = 1'b0;
        lat = -1;
        for (int k = 1; k <= 200; k++) begin
            @(posedge clk); #1;
            if (out_valid4) begin
                lat = k;
                break;
            end
        end
        uo = u4;
        zo = zero_w4;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        total++; if (in_ready9 !== 1'b0) begin bad++; $display("FAIL reset_in_ready got=%b want=0", in_ready9); end
        total++; if (out_valid9 !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid9); end
        total++; if (u9 !== 16'h0000) begin bad++; $display("FAIL reset_u got=%h want=0000", u9); end
        total++; if (zero_w9 !== 1'b0) begin bad++; $display("FAIL reset_zero_w got=%b want=0", zero_w9); end
        rst = 1'b0;
        @(posedge clk); #1;
        total++; if (in_ready9 !== 1'b1) begin bad++; $display("FAIL reset_release_in_ready got=%b want=1", in_ready9); end
    endtask

    task automatic test_single_rule();
        int lat; logic [15:0] uo; logic zo;
        clear9();
        wv9[4] = 16'h8000; cv9[4] = 16'h2000;
        do_op9(1'b1, lat, uo, zo);
        total++; if (lat !== 47) begin bad++; $display("FAIL single_latency got=%0d want=47", lat); end
        total++; if (uo !== 16'h2000) begin bad++; $display("FAIL single_u got=%h want=2000", uo); end
        total++; if (zo !== 1'b0) begin bad++; $display("FAIL single_zero_w got=%b want=0", zo); end
    endtask

    task automatic test_two_rules();
        int lat; logic [15:0] uo; logic zo;
        clear9();
        wv9[0] = 16'h4000; cv9[0] = 16'h4000;
        wv9[2] = 16'h2000; cv9[2] = 16'hC000;
        do_op9(1'b1, lat, uo, zo);
        total++; if (lat !== 47) begin bad++; $display("FAIL two_latency got=%0d want=47", lat); end
        total++; if (uo !== 16'h1555) begin bad++; $display("FAIL two_u got=%h want=1555", uo); end
        // Mirror signs: negative quotient truncates toward zero (-5461)
        clear9();
        wv9[0] = 16'h4000; cv9[0] = 16'hC000;
        wv9[2] = 16'h2000; cv9[2] = 16'h4000;
        do_op9(1'b1, lat, uo, zo);
        total++; if (uo !== 16'hEAAB) begin bad++; $display("FAIL two_neg_u got=%h want=eaab", uo); end
        total++; if (zo !== 1'b0) begin bad++; $display("FAIL two_neg_zero_w got=%b want=0", zo); end
    endtask

    task automatic test_zero_weight();
        int lat; logic [15:0] uo; logic zo;
        clear9();
        for (int i = 0; i < 9; i++) cv9[i] = 16'h1234 + 16'(i);
        do_op9(1'b1, lat, uo, zo);
        total++; if (lat !== 10) begin bad++; $display("FAIL zero_latency got=%0d want=10", lat); end
        total++; if (uo !== 16'h0000) begin bad++; $display("FAIL zero_u got=%h want=0000", uo); end
        total++; if (zo !== 1'b1) begin bad++; $display("FAIL zero_zero_w got=%b want=1", zo); end
    endtask

    task automatic test_full_scale();
        int lat; logic [15:0] uo; logic zo;
        for (int i = 0; i < 9; i++) begin wv9[i] = 16'h8000; cv9[i] = 16'h8000; end
        do_op9(1'b1, lat, uo, zo);
        total++; if (uo !== 16'h8000) begin bad++; $display("FAIL full_neg_u got=%h want=8000", uo); end
        total++; if (zo !== 1'b0) begin bad++; $display("FAIL full_neg_zero_w got=%b want=0", zo); end
        for (int i = 0; i < 9; i++) cv9[i] = 16'h7FFF;
        do_op9(1'b1, lat, uo, zo);
        total++; if (uo !== 16'h7FFF) begin bad++; $display("FAIL full_pos_u got=%h want=7fff", uo); end
        total++; if (lat !== 47) begin bad++; $display("FAIL full_pos_latency got=%0d want=47", lat); end
    endtask

    task automatic test_backpressure();
        int lat; logic [15:0] uo; logic zo;
        out_ready9 = 1'b0;
        clear9();
        wv9[0] = 16'h4000; cv9[0] = 16'h4000;
        wv9[2] = 16'h2000; cv9[2] = 16'hC000;
        do_op9(1'b0, lat, uo, zo);
        total++; if (uo !== 16'h1555) begin bad++; $display("FAIL bp_u got=%h want=1555", uo); end
        // A zero-weight op offered while DONE must be ignored
        clear9();
        pack9();
        in_valid9 = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            total++; if (out_valid9 !== 1'b1) begin bad++; $display("FAIL bp_hold_valid cyc=%0d got=%b want=1", k, out_valid9); end
            total++; if (u9 !== 16'h1555) begin bad++; $display("FAIL bp_hold_u cyc=%0d got=%h want=1555", k, u9); end
            total++; if (in_ready9 !== 1'b0) begin bad++; $display("FAIL bp_hold_in_ready cyc=%0d got=%b want=0", k, in_ready9); end
        end
        wv9[4] = 16'h8000; cv9[4] = 16'h2000;
        pack9();
        out_ready9 = 1'b1;
        @(posedge clk); #1;
        total++; if (out_valid9 !== 1'b0) begin bad++; $display("FAIL bp_after_hs_valid got=%b want=0", out_valid9); end
        total++; if (in_ready9 !== 1'b1) begin bad++; $display("FAIL bp_after_hs_in_ready got=%b want=1", in_ready9); end
        total++; if (u9 !== 16'h1555) begin bad++; $display("FAIL bp_u_kept got=%h want=1555", u9); end
        @(posedge clk); #1;
        in_valid9 = 1'b0;
        lat = -1;
        for (int k = 1; k <= 200; k++) begin
            @(posedge clk); #1;
            if (out_valid9) begin lat = k; break; end
        end
        total++; if (lat !== 47) begin bad++; $display("FAIL bp_next_latency got=%0d want=47", lat); end
        total++; if (u9 !== 16'h2000) begin bad++; $display("FAIL bp_next_u got=%h want=2000", u9); end
        total++; if (zero_w9 !== 1'b0) begin bad++; $display("FAIL bp_next_zero_w got=%b want=0", zero_w9); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_div();
        int lat; logic [15:0] uo; logic zo;
        bit seen;
        clear9();
        wv9[0] = 16'h4000; cv9[0] = 16'h4000;
        wv9[2] = 16'h2000; cv9[2] = 16'hC000;
        pack9();
        in_valid9 = 1'b1;
        @(posedge clk); #1;
        in_valid9 = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        total++; if (out_valid9 !== 1'b0) begin bad++; $display("FAIL rstdiv_out_valid got=%b want=0", out_valid9); end
        total++; if (u9 !== 16'h0000) begin bad++; $display("FAIL rstdiv_u got=%h want=0000", u9); end
        total++; if (zero_w9 !== 1'b0) begin bad++; $display("FAIL rstdiv_zero_w got=%b want=0", zero_w9); end
        rst = 1'b0;
        #1;
        total++; if (in_ready9 !== 1'b1) begin bad++; $display("FAIL rstdiv_in_ready got=%b want=1", in_ready9); end
        seen = 1'b0;
        for (int k = 0; k < 60; k++) begin
            @(posedge clk); #1;
            if (out_valid9) seen = 1'b1;
        end
        total++; if (seen !== 1'b0) begin bad++; $display("FAIL rstdiv_stray_valid got=%b want=0", seen); end
        clear9();
        wv9[4] = 16'h8000; cv9[4] = 16'h2000;
        do_op9(1'b1, lat, uo, zo);
        total++; if (uo !== 16'h2000) begin bad++; $display("FAIL rstdiv_rerun_u got=%h want=2000", uo); end
        total++; if (lat !== 47) begin bad++; $display("FAIL rstdiv_rerun_latency got=%0d want=47", lat); end
    endtask

    task automatic test_rules4_consistency();
        int lat9, lat4; logic [15:0] uo9, uo4; logic zo9, zo4;
        wv4[0] = 16'h8000; cv4[0] = 16'h4000;
        wv4[1] = 16'h4000; cv4[1] = 16'hC000;
        wv4[2] = 16'h2000; cv4[2] = 16'h7FFF;
        wv4[3] = 16'h1000; cv4[3] = 16'h8000;
        clear9();
        // Corners of the 3x3 grid carry the rules4 strengths; centre cross stays 0
        wv9[0] = wv4[0]; cv9[0] = cv4[0];
        wv9[2] = wv4[1]; cv9[2] = cv4[1];
        wv9[6] = wv4[2]; cv9[6] = cv4[2];
        wv9[8] = wv4[3]; cv9[8] = cv4[3];
        for (int i = 1; i < 8; i++) if (i != 2 && i != 6) cv9[i] = 16'h5A5A;
        do_op4(lat4, uo4, zo4);
        do_op9(1'b1, lat9, uo9, zo9);
        total++; if (lat4 !== 40) begin bad++; $display("FAIL r4_latency got=%0d want=40", lat4); end
        total++; if (uo4 !== 16'h1999) begin bad++; $display("FAIL r4_u got=%h want=1999", uo4); end
        total++; if (uo9 !== 16'h1999) begin bad++; $display("FAIL r9_corner_u got=%h want=1999", uo9); end
        total++; if (zo4 !== 1'b0) begin bad++; $display("FAIL r4_zero_w got=%b want=0", zo4); end
    endtask

    initial begin
        total = 0;
        bad = 0;
        rst = 1'b1;
        in_valid9 = 1'b0; out_ready9 = 1'b1; w_flat9 = '0; c_flat9 = '0;
        in_valid4 = 1'b0; out_ready4 = 1'b1; w_flat4 = '0; c_flat4 = '0;
        clear9();
        test_reset();
        test_single_rule();
        test_two_rules();
        test_zero_weight();
        test_full_scale();
        test_backpressure();
        test_reset_mid_div();
        test_rules4_consistency();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
